// File: rtl/lsu_ram_ctrl.sv
// Load/store sequencer: validates and lane-maps CPU memory-stage requests onto a
// word-addressed single-port RAM, waits for ack with a timeout, and hands read lanes to extension.
module lsu_ram_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_sign,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_rsp_valid,
    output logic        lsu_rsp_err,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_mask,
    output logic [31:0] ram_w_data,
    input  logic        ram_ack,
    input  logic [31:0] ram_r_data,
    output logic [31:0] ext_r_data,
    output logic [3:0]  ext_r_mask,
    output logic        ext_r_sign_ext
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdat_q, wdat_d;
    logic        err_q, err_d;
    logic [31:0] rdat_q, rdat_d;
    logic [3:0]  xmask_q, xmask_d;
    logic        xsign_q, xsign_d;

    logic [3:0]  req_mask;
    logic        req_bad;
    logic [31:0] req_wdat;

    // Store data is byte-swapped: the right-justified LSB lands in the highest selected lane.
    always_comb begin
        req_mask = '0;
        req_bad  = 1'b0;
        req_wdat = '0;
        case (lsu_size)
            2'b00: begin
                req_mask = 4'b0001 << lsu_addr[1:0];
                req_wdat = {24'b0, lsu_wdata[7:0]} << {lsu_addr[1:0], 3'b000};
            end
            2'b01: begin
                case (lsu_addr[1:0])
                    2'b00: begin
                        req_mask = 4'b0011;
                        req_wdat = {16'b0, lsu_wdata[7:0], lsu_wdata[15:8]};
                    end
                    2'b10: begin
                        req_mask = 4'b1100;
                        req_wdat = {lsu_wdata[7:0], lsu_wdata[15:8], 16'b0};
                    end
                    default: req_bad = 1'b1;
                endcase
            end
            2'b10: begin
                if (lsu_addr[1:0] == 2'b00) begin
                    req_mask = 4'b1111;
                    req_wdat = {lsu_wdata[7:0], lsu_wdata[15:8],
                                lsu_wdata[23:16], lsu_wdata[31:24]};
                end else begin
                    req_bad = 1'b1;
                end
            end
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wdat_d  = wdat_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        xmask_d = xmask_q;
        xsign_d = xsign_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_valid) begin
                    we_d   = lsu_we & ~req_bad;
                    addr_d = {lsu_addr[31:2], 2'b00};
                    mask_d = req_mask;
                    wdat_d = lsu_we ? req_wdat : 32'b0;
                    err_d  = req_bad;
                    cnt_d  = '0;
                    // Mask 0000 makes the extension block output zero for stores and errors.
                    if (lsu_we) begin
                        xmask_d = 4'b0000;
                    end else begin
                        xmask_d = req_bad ? 4'b0000 : req_mask;
                        xsign_d = lsu_sign & (lsu_size != 2'b10);
                    end
                    state_d = req_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (ram_ack) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdat_d = ram_r_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdat_q  <= '0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            xmask_q <= '0;
            xsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            xmask_q <= xmask_d;
            xsign_q <= xsign_d;
        end
    end

    assign lsu_req_ready  = (state_q == S_IDLE) & ~rst;
    assign lsu_rsp_valid  = (state_q == S_RESP);
    assign lsu_rsp_err    = (state_q == S_RESP) & err_q;
    assign ram_req        = (state_q == S_ACCESS);
    assign ram_we         = we_q;
    assign ram_addr       = addr_q;
    assign ram_mask       = mask_q;
    assign ram_w_data     = wdat_q;
    assign ext_r_data     = rdat_q;
    assign ext_r_mask     = xmask_q;
    assign ext_r_sign_ext = xsign_q;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Bench for lsu_ram_ctrl: directed plan cases plus random requests against a byte-level model.
module tb_lsu_ram_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_sign;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic        ram_req, ram_we, ram_ack;
    logic [31:0] ram_addr, ram_w_data, ram_r_data, ext_r_data;
    logic [3:0]  ram_mask, ext_r_mask;
    logic        ext_r_sign_ext;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rdata;
    logic [3:0]  m_xmask;
    logic        m_xsign;

    lsu_ram_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_sign(lsu_sign),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_mask(ram_mask), .ram_w_data(ram_w_data),
        .ram_ack(ram_ack), .ram_r_data(ram_r_data),
        .ext_r_data(ext_r_data), .ext_r_mask(ext_r_mask),
        .ext_r_sign_ext(ext_r_sign_ext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ext();
        chk("ext_data", ext_r_data, m_rdata);
        chk("ext_mask", {28'b0, ext_r_mask}, {28'b0, m_xmask});
        chk("ext_sign", {31'b0, ext_r_sign_ext}, {31'b0, m_xsign});
    endtask

    // ack_dly: ack in the ack_dly-th ACCESS cycle (0 = first); negative = never.
    task automatic xact(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] rdata);
        int          n, off;
        bit          legal, done;
        logic [3:0]  emask;
        logic [31:0] ewd;
        off   = int'(addr[1:0]);
        n     = (size == 2'd3) ? 0 : (1 << size);
        legal = (n != 0) && ((off % n) == 0);
        emask = '0;
        ewd   = '0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                emask[off + i] = 1'b1;
                ewd[8*(off + n - 1 - i) +: 8] = wdata[8*i +: 8];
            end
        end
        if (we) begin
            m_xmask = 4'b0000;
        end else begin
            m_xmask = legal ? emask : 4'b0000;
            m_xsign = sign && (size != 2'd2);
        end

        chk("ready_idle", {31'b0, lsu_req_ready}, 32'd1);
        lsu_req_valid = 1'b1;
        lsu_we = we; lsu_size = size; lsu_sign = sign;
        lsu_addr = addr; lsu_wdata = wdata;
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        lsu_wdata = $urandom;
        chk("ready_busy", {31'b0, lsu_req_ready}, 32'd0);
        chk("ext_mask_acc", {28'b0, ext_r_mask}, {28'b0, m_xmask});
        chk("ext_sign_acc", {31'b0, ext_r_sign_ext}, {31'b0, m_xsign});
        if (!legal) begin
            chk("err_rsp_vld", {31'b0, lsu_rsp_valid}, 32'd1);
            chk("err_rsp_err", {31'b0, lsu_rsp_err}, 32'd1);
            chk("err_no_req", {31'b0, ram_req}, 32'd0);
        end else begin
            chk("ram_we", {31'b0, ram_we}, {31'b0, we});
            chk("ram_addr", ram_addr, {addr[31:2], 2'b00});
            chk("ram_mask", {28'b0, ram_mask}, {28'b0, emask});
            chk("ram_wdata", ram_w_data, we ? ewd : 32'b0);
            done = 0;
            for (int c = 0; c < TMO && !done; c++) begin
                chk("req_held", {31'b0, ram_req}, 32'd1);
                chk("no_early_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
                if (c == ack_dly) begin
                    ram_ack = 1'b1;
                    ram_r_data = rdata;
                end
                @(posedge clk); #1;
                ram_ack = 1'b0;
                ram_r_data = $urandom;
                if (c == ack_dly) begin
                    done = 1;
                    if (!we) m_rdata = rdata;
                    chk("ack_rsp_vld", {31'b0, lsu_rsp_valid}, 32'd1);
                    chk("ack_rsp_err", {31'b0, lsu_rsp_err}, 32'd0);
                end else if (c == TMO - 1) begin
                    chk("tmo_rsp_vld", {31'b0, lsu_rsp_valid}, 32'd1);
                    chk("tmo_rsp_err", {31'b0, lsu_rsp_err}, 32'd1);
                end
            end
            chk("rsp_req_low", {31'b0, ram_req}, 32'd0);
        end
        chk_ext();
        @(posedge clk); #1;
        chk("idle_ready", {31'b0, lsu_req_ready}, 32'd1);
        chk("idle_no_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
        chk("idle_no_req", {31'b0, ram_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00; lsu_sign = 1'b0;
        lsu_addr = '0; lsu_wdata = '0; ram_ack = 1'b0; ram_r_data = '0;
        m_rdata = '0; m_xmask = '0; m_xsign = 1'b0;
        #1;
        chk("rst_ready", {31'b0, lsu_req_ready}, 32'd0);
        chk("rst_req", {31'b0, ram_req}, 32'd0);
        chk("rst_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
        chk_ext();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, lsu_req_ready}, 32'd1);

        xact(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h4433_2211);
        xact(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 3, 32'h8000_0000);
        xact(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 1, 32'h0);
        xact(1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0, 0, 32'h0);
        xact(1'b0, 2'd3, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, -1, 32'hDEAD_BEEF);

        // Ack while idle must be ignored.
        ram_ack = 1'b1; ram_r_data = 32'h1234_5678;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        chk("stray_ack_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
        chk_ext();

        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = int'($urandom_range(0, 4));
            if (dly == 4) dly = -1;
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, dly, $urandom);
        end

        // Reset during the second ACCESS cycle.
        lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_sign = 1'b0;
        lsu_addr = 32'h0000_0400;
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'b0, ram_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req_drop", {31'b0, ram_req}, 32'd0);
        chk("mid_rst_ready", {31'b0, lsu_req_ready}, 32'd0);
        chk("mid_rst_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
        chk("mid_rst_addr", ram_addr, 32'd0);
        chk("mid_rst_mask", {28'b0, ram_mask}, 32'd0);
        m_rdata = '0; m_xmask = '0; m_xsign = 1'b0;
        chk_ext();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("rerst_no_rsp", {31'b0, lsu_rsp_valid}, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
